// File: rtl/count_wrap_logger_if.sv
// Counter-monitor bus: sampled counter controls in, queued event stream out (valid/ready).
// ev_ts exists only when COUNT_LOG_TS_EN is defined.
interface count_wrap_logger_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
`ifdef COUNT_LOG_TS_EN
   , parameter int TS_WIDTH = 16
`endif
);
   logic [WIDTH-1:0]       count_in;
   logic                   load_in;
   logic                   up_down_in;
   logic                   ev_valid;
   logic                   ev_ready;
   logic [1:0]             ev_type;
   logic [WIDTH-1:0]       ev_count;
`ifdef COUNT_LOG_TS_EN
   logic [TS_WIDTH-1:0]    ev_ts;
`endif
   logic                   ev_overflow;
   logic [$clog2(DEPTH):0] ev_level;

   modport master (
`ifdef COUNT_LOG_TS_EN
      input  ev_ts,
`endif
      output count_in, load_in, up_down_in, ev_ready,
      input  ev_valid, ev_type, ev_count, ev_overflow, ev_level
   );

   modport slave (
`ifdef COUNT_LOG_TS_EN
      output ev_ts,
`endif
      input  count_in, load_in, up_down_in, ev_ready,
      output ev_valid, ev_type, ev_count, ev_overflow, ev_level
   );
endinterface

// File: rtl/count_wrap_logger.sv
// Event logger for the modulo counter: classifies wrap/load/illegal samples into a FWFT FIFO; push-to-valid 1 cycle.
// Consumer stalls with ev_ready=0; a push into a full FIFO without a pop is dropped and flagged. Timestamps via COUNT_LOG_TS_EN.
module count_wrap_logger_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   i_push_vld,
   input  logic [W-1:0]           i_push_dat,
   input  logic                   i_pop_rdy,
   output logic                   o_pop_vld,
   output logic [W-1:0]           o_pop_dat,
   output logic                   o_drop,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_full;
   logic          w_pop;
   logic          w_push;

   assign w_full    = (r_level == (AW+1)'(DEPTH));
   assign o_pop_vld = (r_level != '0);
   assign w_pop     = o_pop_vld & i_pop_rdy;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
   assign w_push    = i_push_vld & (~w_full | w_pop);
   assign o_drop    = i_push_vld & w_full & ~w_pop;
   assign o_pop_dat = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
   end
endmodule

module count_wrap_logger #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 11,
   parameter int DEPTH     = 8
`ifdef COUNT_LOG_TS_EN
   , parameter int TS_WIDTH = 16
`endif
) (
   input logic                 clock,
   input logic                 resetn,
   count_wrap_logger_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);

   typedef enum logic [1:0] {
      EV_WRAP_UP = 2'b00,
      EV_WRAP_DN = 2'b01,
      EV_LOAD    = 2'b10,
      EV_ILLEGAL = 2'b11
   } ev_type_e;

   typedef struct packed {
`ifdef COUNT_LOG_TS_EN
      logic [TS_WIDTH-1:0] ts;
`endif
      ev_type_e            typ;
      logic [WIDTH-1:0]    cnt;
   } ev_t;

   logic [WIDTH-1:0] r_prev_count;
   logic             r_prev_load;
   logic             r_prev_ud;
   logic             r_armed;
   logic             r_overflow;
   ev_t              w_ev;
   logic             w_ev_vld;
   ev_t              w_head;
   logic             w_head_vld;
   logic             w_drop;
`ifdef COUNT_LOG_TS_EN
   logic [TS_WIDTH-1:0] r_ts;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_ts <= '0;
      else         r_ts <= r_ts + TS_WIDTH'(1);
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_prev_count <= '0;
         r_prev_load  <= 1'b0;
         r_prev_ud    <= 1'b0;
         r_armed      <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_prev_count <= bus.count_in;
         r_prev_load  <= bus.load_in;
         r_prev_ud    <= bus.up_down_in;
         r_armed      <= 1'b1;
         r_overflow   <= r_overflow | w_drop;
      end
   end

   // Priority: ILLEGAL > LOAD > wraps; a load reports the value it produced.
   always_comb begin
      w_ev     = '0;
      w_ev_vld = 1'b0;
      w_ev.cnt = bus.count_in;
`ifdef COUNT_LOG_TS_EN
      w_ev.ts  = r_ts;
`endif
      if (r_armed) begin
         if (bus.count_in > MAXC) begin
            w_ev_vld = 1'b1;
            w_ev.typ = EV_ILLEGAL;
         end else if (r_prev_load) begin
            w_ev_vld = 1'b1;
            w_ev.typ = EV_LOAD;
         end else if (r_prev_ud && r_prev_count == MAXC && bus.count_in == '0) begin
            w_ev_vld = 1'b1;
            w_ev.typ = EV_WRAP_UP;
         end else if (!r_prev_ud && r_prev_count == '0 && bus.count_in == MAXC) begin
            w_ev_vld = 1'b1;
            w_ev.typ = EV_WRAP_DN;
         end
      end
   end

   count_wrap_logger_fifo #(
      .W     ($bits(ev_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .resetn     (resetn),
      .i_push_vld (w_ev_vld),
      .i_push_dat (w_ev),
      .i_pop_rdy  (bus.ev_ready),
      .o_pop_vld  (w_head_vld),
      .o_pop_dat  (w_head),
      .o_drop     (w_drop),
      .o_level    (bus.ev_level)
   );

   // Head fields read as zero while empty so stale RAM never reaches the port.
   assign bus.ev_valid    = w_head_vld;
   assign bus.ev_type     = w_head_vld ? w_head.typ : 2'b00;
   assign bus.ev_count    = w_head_vld ? w_head.cnt : '0;
`ifdef COUNT_LOG_TS_EN
   assign bus.ev_ts       = w_head_vld ? w_head.ts : '0;
`endif
   assign bus.ev_overflow = r_overflow;
endmodule

// File: tb/tb_count_wrap_logger.sv
// Directed scenarios plus randomized counter traffic against a queue-based event model.
module tb_count_wrap_logger;
   localparam int WIDTH = 4;
   localparam int MAXC  = 11;
   localparam int DEPTH = 8;

   typedef struct {
      logic [1:0]  t;
      logic [3:0]  c;
      logic [15:0] ts;
   } mev_t;

   logic clock;
   logic resetn;
   int   n_vec;
   int   n_err;

   mev_t mq[$];
   bit   m_armed;
   bit   m_ovf;
   int   m_pc;
   bit   m_pl;
   bit   m_pu;
   int   m_cyc;

   count_wrap_logger_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   count_wrap_logger #(.WIDTH(WIDTH), .MAX_COUNT(MAXC), .DEPTH(DEPTH)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_armed = 0;
      m_ovf   = 0;
      m_pc    = 0;
      m_pl    = 0;
      m_pu    = 0;
      m_cyc   = 0;
   endtask

   task automatic model_edge(input int c, input bit ld, input bit ud, input bit rdy);
      bit   pop;
      bit   hit;
      mev_t e;
      pop  = rdy && (mq.size() != 0);
      hit  = 1'b0;
      e.c  = 4'(c);
      e.ts = 16'(m_cyc);
      e.t  = 2'b00;
      if (m_armed) begin
         if (c > MAXC)                                      begin hit = 1; e.t = 2'b11; end
         else if (m_pl)                                     begin hit = 1; e.t = 2'b10; end
         else if (m_pu && m_pc == MAXC && c == 0)           begin hit = 1; e.t = 2'b00; end
         else if (!m_pu && m_pc == 0 && c == MAXC)          begin hit = 1; e.t = 2'b01; end
      end
      if (hit && mq.size() == DEPTH && !pop) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (hit && !(mq.size() == DEPTH)) mq.push_back(e);
      m_pc    = c;
      m_pl    = ld;
      m_pu    = ud;
      m_armed = 1;
      m_cyc++;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, bus.ev_valid, mq.size() != 0);
      chk({tag, ".level"}, bus.ev_level, mq.size());
      chk({tag, ".ovf"},   bus.ev_overflow, m_ovf);
      if (mq.size() != 0) begin
         chk({tag, ".type"},  bus.ev_type,  mq[0].t);
         chk({tag, ".count"}, bus.ev_count, mq[0].c);
`ifdef COUNT_LOG_TS_EN
         chk({tag, ".ts"},    bus.ev_ts,    mq[0].ts);
`endif
      end
   endtask

   task automatic step(input int c, input bit ld, input bit ud, input bit rdy, input string tag);
      bus.count_in   = 4'(c);
      bus.load_in    = ld;
      bus.up_down_in = ud;
      bus.ev_ready   = rdy;
      @(posedge clock);
      model_edge(c, ld, ud, rdy);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      resetn = 1'b0;
      #1;
      model_reset();
      chk({tag, ".rst_valid"}, bus.ev_valid, 1'b0);
      chk({tag, ".rst_level"}, bus.ev_level, 0);
      chk({tag, ".rst_type"},  bus.ev_type, 0);
      chk({tag, ".rst_count"}, bus.ev_count, 0);
      chk({tag, ".rst_ovf"},   bus.ev_overflow, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      int cv;
      bit pl;
      bit pu;
      int c;
      bit ld;
      bit ud;
      bit rdy;
      clock = 1'b0;
      resetn = 1'b0;
      n_vec = 0;
      n_err = 0;
      bus.count_in = '0;
      bus.load_in = 1'b0;
      bus.up_down_in = 1'b0;
      bus.ev_ready = 1'b0;
      model_reset();
      #2;
      do_reset("init");

      // Up-count through terminal count: a single WRAP_UP reporting 0.
      for (int i = 0; i <= MAXC; i++) step(i, 0, 1, 0, "up");
      step(0, 0, 1, 0, "up_wrap");
      chk("up.one_event", bus.ev_level, 1);
      chk("up.wrap_type", bus.ev_type, 2'b00);
      chk("up.wrap_count", bus.ev_count, 0);
      step(0, 0, 1, 1, "up_drain");

      // Load 5 while counting down, then wrap down to 11.
      step(8, 1, 0, 0, "dn_ld");
      step(5, 0, 0, 0, "dn_loaded");
      for (int i = 4; i >= 0; i--) step(i, 0, 0, 0, "dn");
      step(MAXC, 0, 0, 0, "dn_wrap");
      chk("dn.level", bus.ev_level, 2);
      chk("dn.load_type", bus.ev_type, 2'b10);
      chk("dn.load_count", bus.ev_count, 5);
      step(MAXC, 0, 0, 1, "dn_pop1");
      chk("dn.wrap_type", bus.ev_type, 2'b01);
      chk("dn.wrap_count", bus.ev_count, MAXC);
      step(MAXC, 0, 0, 1, "dn_pop2");

      // Illegal value on the loaded cycle wins over LOAD.
      step(7, 1, 0, 0, "ill_ld");
      step(13, 0, 0, 0, "ill");
      chk("ill.level", bus.ev_level, 1);
      chk("ill.type", bus.ev_type, 2'b11);
      chk("ill.count", bus.ev_count, 13);
      step(5, 0, 0, 1, "ill_drain");

      // Fill to DEPTH, then push and pop together: no drop.
      for (int i = 0; i <= DEPTH; i++) step(i, 1, 1, 0, "fill");
      chk("full.level", bus.ev_level, DEPTH);
      step(9, 1, 1, 1, "full_pushpop");
      chk("full_pp.level", bus.ev_level, DEPTH);
      chk("full_pp.ovf", bus.ev_overflow, 1'b0);

      // Push into a full FIFO without pop: dropped, sticky overflow.
      step(10, 0, 1, 0, "ovf");
      chk("ovf.level", bus.ev_level, DEPTH);
      chk("ovf.flag", bus.ev_overflow, 1'b1);
      chk("ovf.head", bus.ev_count, 2);
      for (int i = 0; i < DEPTH; i++) step(3, 0, 1, 1, "ovf_drain");
      chk("ovf.sticky", bus.ev_overflow, 1'b1);

      // Reset with three events queued; the first post-reset sample never logs.
      step(0, 1, 1, 0, "q3");
      step(1, 1, 1, 0, "q3");
      step(2, 1, 1, 0, "q3");
      step(MAXC, 0, 1, 0, "q3");
      chk("q3.level", bus.ev_level, 3);
      bus.count_in = 4'(MAXC);
      do_reset("midrst");
      step(0, 0, 1, 0, "post_rst");
      chk("post_rst.level", bus.ev_level, 0);
      step(1, 0, 1, 0, "post_rst2");

      // Randomized counter traffic with loads, illegal spikes and bursty consumer.
      cv = 1;
      pl = 0;
      pu = 1;
      for (int i = 0; i < 400; i++) begin
         if (pl)      cv = $urandom_range(0, MAXC);
         else if (pu) cv = (cv == MAXC) ? 0 : cv + 1;
         else         cv = (cv == 0) ? MAXC : cv - 1;
         c   = ($urandom_range(0, 24) == 0) ? $urandom_range(MAXC + 1, 15) : cv;
         ld  = ($urandom_range(0, 9) == 0);
         ud  = ($urandom_range(0, 3) != 0) ? pu : ~pu;
         rdy = ((i % 64) < 24) ? 1'b0 : 1'($urandom_range(0, 1));
         step(c, ld, ud, rdy, "rand");
         pl = ld;
         pu = ud;
         if (i == 200) begin
            do_reset("rand_rst");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
